// File: rtl/segmux_pkg.sv
// Shared definitions for the segmux_display driver: glyph encoding, fixed
// segment patterns and the binary-to-BCD converter state type.
package segmux_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;

   typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;

   // Active-low a..g pattern for one hex nibble (dp not included).
   function automatic logic [6:0] glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

   // Decimal digits needed for 2**w - 1 (1233/4096 approximates log10(2)).
   function automatic int unsigned dec_digits(input int unsigned w);
      return ((w * 1233) >> 12) + 1;
   endfunction

endpackage

// File: rtl/segmux_display_if.sv
// Load/display bus of segmux_display: the datapath side drives the value
// and strobes (master), the display driver returns status and pin levels (slave).
interface segmux_display_if #(
   parameter int unsigned NDIGITS = 4,
   parameter int unsigned BIN_W   = 13
);
   logic [BIN_W-1:0]   bin;
   logic               load;
   logic               dec_mode;
   logic [NDIGITS-1:0] dp_mask;
   logic               ready;
   logic               ovf;
   logic [7:0]         seg;
   logic [NDIGITS-1:0] an;

   modport master (
      output bin, load, dec_mode, dp_mask,
      input  ready, ovf, seg, an
   );

   modport slave (
      input  bin, load, dec_mode, dp_mask,
      output ready, ovf, seg, an
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per clk, BIN_W
// steps per conversion, with start/busy/done handshake and overflow flag.
module bin2bcd_seq
   import segmux_pkg::*;
#(
   parameter int unsigned BIN_W   = 13,
   parameter int unsigned NDIGITS = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [BIN_W-1:0]       bin,
   output logic                   busy,
   output logic                   done,
   output logic [4*NDIGITS-1:0]   bcd,
   output logic                   ovf
);

   // Accumulator is wide enough for the full input range so overflow is exact.
   localparam int unsigned FULL_D = dec_digits(BIN_W);
   localparam int unsigned ACC_D  = (FULL_D > NDIGITS) ? FULL_D : NDIGITS;
   localparam int unsigned ACC_W  = 4 * ACC_D;
   localparam int unsigned CW     = $clog2(BIN_W + 1);

   conv_state_t       state;
   logic [BIN_W-1:0]  sh;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  adj;
   logic [ACC_W-1:0]  acc_nxt;
   logic [CW-1:0]     cnt;
   logic              ovf_nxt;

   always_comb begin
      adj = acc;
      for (int unsigned d = 0; d < ACC_D; d++) begin
         if (adj[4*d +: 4] >= 4'd5)
            adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
      end
      acc_nxt = {adj[ACC_W-2:0], sh[BIN_W-1]};
      ovf_nxt = 1'b0;
      for (int unsigned d = NDIGITS; d < ACC_D; d++)
         ovf_nxt = ovf_nxt | (|acc_nxt[4*d +: 4]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sh    <= '0;
         acc   <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         bcd   <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sh    <= bin;
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CONV;
               end
            end
            CONV: begin
               acc <= acc_nxt;
               sh  <= sh << 1;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(BIN_W - 1)) begin
                  state <= DONE;
                  done  <= 1'b1;
                  bcd   <= acc_nxt[4*NDIGITS-1:0];
                  ovf   <= ovf_nxt;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/segmux_display.sv
// Multiplexed common-anode 7-segment driver showing a loaded value in hex or
// decimal. Optional leading-zero blanking in decimal mode: SEGMUX_LZ_BLANK_EN.
module segmux_display
   import segmux_pkg::*;
#(
   parameter int unsigned NDIGITS     = 4,
   parameter int unsigned BIN_W       = 13,
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   segmux_display_if.slave   bus
);

   localparam int unsigned DW = 4 * NDIGITS;
   localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam int unsigned PW = $clog2(REFRESH_DIV);

   logic [PW-1:0]        pre;
   logic [IW-1:0]        idx;
   logic [DW-1:0]        disp;
   logic                 ovf_q;
   logic [7:0]           seg_q;
   logic [NDIGITS-1:0]   an_q;
   logic                 c_busy;
   logic                 c_done;
   logic                 c_ovf;
   logic [DW-1:0]        c_bcd;
   logic                 accept;
   logic [DW+BIN_W-1:0]  bin_ext;
   logic [3:0]           cur_nib;
   logic                 cur_dp;
   logic                 blank;
   logic [NDIGITS-1:0]   an_nxt;

   assign accept  = bus.load && !c_busy;
   assign bin_ext = {{DW{1'b0}}, bus.bin};

   bin2bcd_seq #(
      .BIN_W   (BIN_W),
      .NDIGITS (NDIGITS)
   ) u_conv (
      .clk   (clk),
      .rst_n (rst_n),
      .start (accept && bus.dec_mode),
      .bin   (bus.bin),
      .busy  (c_busy),
      .done  (c_done),
      .bcd   (c_bcd),
      .ovf   (c_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp  <= '0;
         ovf_q <= 1'b0;
      end else if (accept && !bus.dec_mode) begin
         disp  <= bin_ext[DW-1:0];
         ovf_q <= 1'b0;
      end else if (c_done) begin
         disp  <= c_bcd;
         ovf_q <= c_ovf;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= '0;
         idx <= '0;
      end else if (pre == PW'(REFRESH_DIV - 1)) begin
         pre <= '0;
         idx <= (idx == IW'(NDIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
         pre <= pre + PW'(1);
      end
   end

`ifdef SEGMUX_LZ_BLANK_EN
   logic                dec_shown;
   logic [NDIGITS-1:0]  lz;
   logic                hz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         dec_shown <= 1'b0;
      else if (accept && !bus.dec_mode)
         dec_shown <= 1'b0;
      else if (c_done)
         dec_shown <= 1'b1;
   end

   // lz[i]: digit i and every digit above it are zero; digit 0 never qualifies.
   always_comb begin
      lz = '0;
      hz = 1'b1;
      for (int unsigned k = 0; k + 1 < NDIGITS; k++) begin
         hz = hz & (disp[4*(NDIGITS-1-k) +: 4] == 4'd0);
         lz[NDIGITS-1-k] = hz;
      end
   end
`endif

   always_comb begin
      cur_nib = '0;
      cur_dp  = 1'b0;
      blank   = 1'b0;
      an_nxt  = '1;
      for (int unsigned i = 0; i < NDIGITS; i++) begin
         if (idx == IW'(i)) begin
            cur_nib   = disp[4*i +: 4];
            cur_dp    = bus.dp_mask[i];
            an_nxt[i] = 1'b0;
`ifdef SEGMUX_LZ_BLANK_EN
            blank     = dec_shown && !ovf_q && lz[i];
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q <= SEG_BLANK;
         an_q  <= '1;
      end else if (blank) begin
         seg_q <= SEG_BLANK;
         an_q  <= '1;
      end else begin
         seg_q <= ovf_q ? {~cur_dp, SEG_DASH[6:0]} : {~cur_dp, glyph(cur_nib)};
         an_q  <= an_nxt;
      end
   end

   assign bus.ready = !c_busy;
   assign bus.ovf   = ovf_q;
   assign bus.seg   = seg_q;
   assign bus.an    = an_q;

endmodule

// File: tb/tb_segmux_display.sv
// Scoreboard bench for segmux_display: two instances (13-bit and 14-bit
// input), directed scenarios plus random loads checked against a digit model.
module tb_segmux_display;

   localparam int ND  = 4;
   localparam int RD  = 4;
   localparam int BWA = 13;
   localparam int BWB = 14;

   localparam logic [7:0] GLY [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   typedef struct packed {
      logic [ND-1:0]      lit;
      logic [ND-1:0][7:0] seg;
      logic               ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        sel = 1'b0;
   logic        load_v = 1'b0;
   logic        dec_v = 1'b0;
   logic [13:0] bin_v = '0;
   logic [3:0]  dp_v = '0;

   int n_tests = 0;
   int n_fail = 0;
   int pushed = 0;
   int mon_done = 0;
   exp_t sbq[$];

   segmux_display_if #(.NDIGITS(ND), .BIN_W(BWA)) bus_a ();
   segmux_display_if #(.NDIGITS(ND), .BIN_W(BWB)) bus_b ();

   segmux_display #(.NDIGITS(ND), .BIN_W(BWA), .REFRESH_DIV(RD)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a));
   segmux_display #(.NDIGITS(ND), .BIN_W(BWB), .REFRESH_DIV(RD)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b));

   assign bus_a.bin      = bin_v[12:0];
   assign bus_a.load     = load_v & ~sel;
   assign bus_a.dec_mode = dec_v;
   assign bus_a.dp_mask  = dp_v;
   assign bus_b.bin      = bin_v;
   assign bus_b.load     = load_v & sel;
   assign bus_b.dec_mode = dec_v;
   assign bus_b.dp_mask  = dp_v;

   logic [7:0] m_seg;
   logic [3:0] m_an;
   logic       m_ready;
   logic       m_ovf;
   assign m_seg   = sel ? bus_b.seg   : bus_a.seg;
   assign m_an    = sel ? bus_b.an    : bus_a.an;
   assign m_ready = sel ? bus_b.ready : bus_a.ready;
   assign m_ovf   = sel ? bus_b.ovf   : bus_a.ovf;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int p10(input int i);
      int r = 1;
      for (int k = 0; k < i; k++) r = r * 10;
      return r;
   endfunction

   // Expected per-digit appearance from the value itself, not from any BCD pipeline.
   function automatic exp_t model(input int v, input bit dec, input logic [3:0] dp);
      exp_t e;
      int d;
      logic [7:0] g;
      e.lit = '1;
      e.ovf = dec && (v > p10(ND) - 1);
      for (int i = 0; i < ND; i++) begin
         if (e.ovf) begin
            e.seg[i] = {~dp[i], 7'h3F};
         end else begin
            d = dec ? (v / p10(i)) % 10 : (v >> (4 * i)) & 15;
            g = GLY[d];
            e.seg[i] = {~dp[i], g[6:0]};
         end
`ifdef SEGMUX_LZ_BLANK_EN
         if (dec && !e.ovf && i > 0 && v < p10(i)) begin
            e.lit[i] = 1'b0;
            e.seg[i] = 8'hFF;
         end
`endif
      end
      return e;
   endfunction

   task automatic summary_and_stop();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "bench stopped early");
   endtask

   task automatic do_load(input bit s, input int v, input bit dec, input logic [3:0] dp, input bit track);
      @(negedge clk);
      sel = s; dp_v = dp; bin_v = 14'(v); dec_v = dec; load_v = 1'b1;
      @(negedge clk);
      load_v = 1'b0;
      if (track) begin
         sbq.push_back(model(v, dec, dp));
         pushed++;
      end
   endtask

   task automatic check_latency(input int req);
      int cnt = 0;
      while (m_ready === 1'b0 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      chk("busy_cycles", 32'(cnt), 32'(req));
   endtask

   task automatic wait_mon();
      int t = 0;
      while (mon_done != pushed && t < 400) begin
         t++;
         @(negedge clk);
      end
      if (mon_done != pushed) begin
         n_tests++; n_fail++;
         $display("FAIL monitor_stall actual=%0d required=%0d", mon_done, pushed);
         summary_and_stop();
      end
   endtask

   task automatic scan_order();
      logic [3:0] prev, cur;
      int run = 0;
      bit started = 0;
      prev = m_an;
      repeat (4 * ND * RD) begin
         @(negedge clk);
         cur = m_an;
         if (cur == prev) begin
            run++;
         end else begin
            if (started) chk("slot_len", 32'(run), 32'(RD));
            chk("slot_next", 32'(cur), 32'({prev[2:0], prev[3]}));
            started = 1;
            run = 1;
            prev = cur;
         end
      end
   endtask

   // Monitor: once the DUT is ready again and the display settled, scan and compare.
   initial begin : monitor
      exp_t e;
      logic [ND-1:0] seen, bad;
      logic [7:0] act [ND];
      logic [3:0] oc;
      int badan, t;
      bit hit;
      forever begin
         while (sbq.size() == 0) @(negedge clk);
         e = sbq.pop_front();
         t = 0;
         while (m_ready !== 1'b1 && t < 60) begin t++; @(negedge clk); end
         chk("ready_return", 32'(m_ready), 32'd1);
         @(posedge clk); @(posedge clk); @(negedge clk);
         seen = '0; bad = '0; badan = 0;
         for (int i = 0; i < ND; i++) act[i] = 8'h00;
         repeat (2 * ND * RD) begin
            if (m_an == 4'hF) begin
               if (m_seg !== 8'hFF) badan++;
            end else begin
               hit = 0;
               for (int i = 0; i < ND; i++) begin
                  oc = ~(4'b0001 << i);
                  if (m_an == oc) begin
                     hit = 1;
                     seen[i] = 1'b1;
                     if (!bad[i]) act[i] = m_seg;
                     if (m_seg !== e.seg[i]) bad[i] = 1'b1;
                  end
               end
               if (!hit) badan++;
            end
            @(negedge clk);
         end
         chk("ovf", 32'(m_ovf), 32'(e.ovf));
         chk("an_shape", 32'(badan), 32'd0);
         for (int i = 0; i < ND; i++) begin
            chk($sformatf("lit_d%0d", i), 32'(seen[i]), 32'(e.lit[i]));
            if (e.lit[i]) chk($sformatf("seg_d%0d", i), 32'(act[i]), 32'(e.seg[i]));
         end
         mon_done++;
      end
   end

   initial begin : watchdog
      #2000000;
      n_tests++; n_fail++;
      $display("FAIL watchdog actual=timeout required=finish");
      summary_and_stop();
   end

   initial begin : stim
      int v;
      bit s, dec;
      logic [3:0] dp;

      #2 rst_n = 1'b0;
      #6;
      sel = 1'b0;
      #1;
      chk("rst_seg", 32'(m_seg), 32'hFF);
      chk("rst_an", 32'(m_an), 32'hF);
      chk("rst_ready", 32'(m_ready), 32'd1);
      chk("rst_ovf", 32'(m_ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("first_digit_an", 32'(m_an), 32'hE);
      chk("first_digit_seg", 32'(m_seg), 32'hC0);

      // Hex 1A3F with scan order/timing.
      do_load(1'b0, 13'h1A3F, 1'b0, 4'b0000, 1'b1);
      chk("hex_ready", 32'(m_ready), 32'd1);
      wait_mon();
      scan_order();

      // Decimal 4095: 14 busy cycles then 5,9,0,4.
      do_load(1'b0, 4095, 1'b1, 4'b0000, 1'b1);
      check_latency(BWA + 1);
      wait_mon();

      // Overflow on the 14-bit instance, then cleared by a hex load.
      do_load(1'b1, 12345, 1'b1, 4'b0000, 1'b1);
      check_latency(BWB + 1);
      wait_mon();
      do_load(1'b1, 0, 1'b0, 4'b0000, 1'b1);
      wait_mon();

      // Load while busy must be ignored.
      do_load(1'b0, 1234, 1'b1, 4'b0000, 1'b1);
      @(negedge clk); @(negedge clk);
      chk("busy_ready", 32'(m_ready), 32'd0);
      bin_v = 14'd7; load_v = 1'b1;
      @(negedge clk);
      load_v = 1'b0;
      wait_mon();

      // Decimal point on digit 1 only.
      do_load(1'b0, 13'h0C5A, 1'b0, 4'b0010, 1'b1);
      wait_mon();

      // Small decimal value (leading zeros shown or blanked).
      do_load(1'b0, 7, 1'b1, 4'b0000, 1'b1);
      check_latency(BWA + 1);
      wait_mon();

      for (int k = 0; k < 16; k++) begin
         s   = 1'($urandom_range(0, 1));
         dec = 1'($urandom_range(0, 1));
         v   = s ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 8191));
         dp  = 4'($urandom_range(0, 15));
         do_load(s, v, dec, dp, 1'b1);
         if (dec) check_latency((s ? BWB : BWA) + 1);
         else chk("hex_ready", 32'(m_ready), 32'd1);
         wait_mon();
      end

      // Reset in the middle of a conversion.
      do_load(1'b0, 4095, 1'b1, 4'b0000, 1'b0);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_seg", 32'(m_seg), 32'hFF);
      chk("midrst_an", 32'(m_an), 32'hF);
      chk("midrst_ready", 32'(m_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("postrst_an", 32'(m_an), 32'hE);
      chk("postrst_seg", 32'(m_seg), 32'hC0);
      chk("postrst_ready", 32'(m_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
